// File: rtl/fetch_ifid.sv
// Instruction fetch plus IF/ID pipeline register with halt-drain sequencing.
// Optional FETCH_STATS_EN adds saturating stall/flush counters.
module fetch_ifid #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] NOP_INSTR    = 16'h0800,
    parameter logic [15:0] HALT_INSTR   = 16'h0000,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcWrite,
    input  logic        ifid_write,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_addr,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_PC,
    output logic        ifid_valid,
`ifdef FETCH_STATS_EN
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
`endif
    output logic        halted
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_ifpc;
    logic        r_valid;
    logic [1:0]  r_state;
    logic [7:0]  r_cnt;

    logic [15:0] w_pc_inc;
    logic        w_halt_hit;
    logic        w_redir_ok;

    assign w_pc_inc   = r_pc + 16'd2;
    assign w_halt_hit = (r_state == ST_RUN) && r_valid && (r_instr == HALT_INSTR);
    assign w_redir_ok = redirect && (r_state != ST_HALTED);

    assign imem_addr  = r_pc;
    assign ifid_instr = r_instr;
    assign ifid_PC    = r_ifpc;
    assign ifid_valid = r_valid;
    assign halted     = (r_state == ST_HALTED);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_ifpc  <= 16'h0000;
            r_valid <= 1'b0;
            r_state <= ST_RUN;
            r_cnt   <= 8'd0;
        end else if (w_redir_ok) begin
            r_pc    <= {redirect_pc[15:1], 1'b0};
            r_instr <= NOP_INSTR;
            r_ifpc  <= 16'h0000;
            r_valid <= 1'b0;
            r_state <= ST_RUN;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_halt_hit) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= DRAIN_LOAD;
                        r_instr <= NOP_INSTR;
                        r_ifpc  <= 16'h0000;
                        r_valid <= 1'b0;
                    end else begin
                        if (pcWrite) r_pc <= w_pc_inc;
                        if (ifid_write) begin
                            r_instr <= imem_data;
                            r_ifpc  <= w_pc_inc;
                            r_valid <= 1'b1;
                        end
                    end
                end
                // The halt-detect edge is the first of the DRAIN_CYCLES edges.
                ST_DRAIN: begin
                    if (r_cnt <= 8'd1) begin
                        r_state <= ST_HALTED;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_HALTED: ;
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= 16'h0000;
            r_flush_cnt <= 16'h0000;
        end else if (r_state == ST_RUN) begin
            if (redirect)     r_flush_cnt <= sat_inc(r_flush_cnt);
            else if (!pcWrite) r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed-vector bench for fetch_ifid: reset, stall, redirect, wrap, halt drain.
module tb_fetch_ifid;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcWrite;
    logic        ifid_write;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_PC;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    logic        halt_en;
    logic [15:0] halt_addr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Instruction memory: A000+addr everywhere, except an optional HALT word.
    assign imem_data = (halt_en && imem_addr == halt_addr) ? 16'h0000 : 16'hA000 + imem_addr;

    fetch_ifid dut (
        .clk         (clk),
        .rst         (rst),
        .pcWrite     (pcWrite),
        .ifid_write  (ifid_write),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_data   (imem_data),
        .imem_addr   (imem_addr),
        .ifid_instr  (ifid_instr),
        .ifid_PC     (ifid_PC),
        .ifid_valid  (ifid_valid),
`ifdef FETCH_STATS_EN
        .stall_count (stall_count),
        .flush_count (flush_count),
`endif
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; pcWrite = 1'b1; ifid_write = 1'b1; redirect = 1'b0;
        redirect_pc = 16'h0000; halt_en = 1'b0; halt_addr = 16'h0000;

        step(); step();
        check("rst_addr",   imem_addr,  16'h0000);
        check("rst_instr",  ifid_instr, 16'h0800);
        check("rst_ifpc",   ifid_PC,    16'h0000);
        check("rst_valid",  {15'd0, ifid_valid}, 16'd0);
        check("rst_halted", {15'd0, halted},     16'd0);
`ifdef FETCH_STATS_EN
        check("rst_stall", stall_count, 16'd0);
        check("rst_flush", flush_count, 16'd0);
`endif

        rst = 1'b1;
        step();
        check("run1_addr",  imem_addr,  16'h0002);
        check("run1_instr", ifid_instr, 16'hA000);
        check("run1_ifpc",  ifid_PC,    16'h0002);
        check("run1_valid", {15'd0, ifid_valid}, 16'd1);
        step();
        check("run2_addr",  imem_addr,  16'h0004);
        check("run2_instr", ifid_instr, 16'hA002);
        step();
        check("run3_addr",  imem_addr,  16'h0006);
        check("run3_instr", ifid_instr, 16'hA004);

        pcWrite = 1'b0; ifid_write = 1'b0;
        step();
        check("stall_addr",  imem_addr,  16'h0006);
        check("stall_instr", ifid_instr, 16'hA004);
        check("stall_ifpc",  ifid_PC,    16'h0006);
        pcWrite = 1'b1; ifid_write = 1'b1;
        step();
        check("resume_addr",  imem_addr,  16'h0008);
        check("resume_instr", ifid_instr, 16'hA006);
        check("resume_ifpc",  ifid_PC,    16'h0008);

        redirect = 1'b1; redirect_pc = 16'h0041; pcWrite = 1'b0;
        step();
        check("redir_addr",  imem_addr,  16'h0040);
        check("redir_instr", ifid_instr, 16'h0800);
        check("redir_valid", {15'd0, ifid_valid}, 16'd0);
`ifdef FETCH_STATS_EN
        check("redir_flush", flush_count, 16'd1);
        check("redir_stall", stall_count, 16'd1);
`endif
        redirect = 1'b0; pcWrite = 1'b1;
        step();
        check("tgt_addr",  imem_addr,  16'h0042);
        check("tgt_instr", ifid_instr, 16'hA040);
        check("tgt_ifpc",  ifid_PC,    16'h0042);
        check("tgt_valid", {15'd0, ifid_valid}, 16'd1);

        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step();
        check("wrap_redir_addr", imem_addr, 16'hFFFE);
        redirect = 1'b0;
        step();
        check("wrap_addr",  imem_addr,  16'h0000);
        check("wrap_instr", ifid_instr, 16'h9FFE);
        check("wrap_ifpc",  ifid_PC,    16'h0000);
        step();
        check("wrap2_addr",  imem_addr,  16'h0002);
        check("wrap2_instr", ifid_instr, 16'hA000);

        halt_en = 1'b1; halt_addr = 16'h0004;
        step();
        check("pre_halt_addr", imem_addr, 16'h0004);
        step();
        check("halt_latched", ifid_instr, 16'h0000);
        check("halt_latched_valid", {15'd0, ifid_valid}, 16'd1);
        step();
        check("drain1_addr",   imem_addr, 16'h0006);
        check("drain1_valid",  {15'd0, ifid_valid}, 16'd0);
        check("drain1_halted", {15'd0, halted}, 16'd0);
        step();
        check("drain2_addr",   imem_addr, 16'h0006);
        check("drain2_halted", {15'd0, halted}, 16'd0);
        step();
        check("halted_addr", imem_addr, 16'h0006);
        check("halted_flag", {15'd0, halted}, 16'd1);
        redirect = 1'b1; redirect_pc = 16'h0100;
        step();
        check("halted_ign_addr", imem_addr, 16'h0006);
        check("halted_ign_flag", {15'd0, halted}, 16'd1);
        redirect = 1'b0;

        rst = 1'b0; halt_en = 1'b0;
        step();
        check("rsth_halted", {15'd0, halted}, 16'd0);
        check("rsth_addr",   imem_addr, 16'h0000);
        check("rsth_valid",  {15'd0, ifid_valid}, 16'd0);
        rst = 1'b1;
        step();
        check("rsth_fetch_addr",  imem_addr,  16'h0002);
        check("rsth_fetch_instr", ifid_instr, 16'hA000);

        halt_en = 1'b1; halt_addr = 16'h0004;
        step();
        step();
        check("c_halt_latched", ifid_instr, 16'h0000);
        step();
        check("c_drain1_addr", imem_addr, 16'h0006);
        step();
        check("c_drain2_halted", {15'd0, halted}, 16'd0);
        redirect = 1'b1; redirect_pc = 16'h0020;
        step();
        check("c_cancel_addr",   imem_addr, 16'h0020);
        check("c_cancel_halted", {15'd0, halted}, 16'd0);
        check("c_cancel_valid",  {15'd0, ifid_valid}, 16'd0);
        redirect = 1'b0; halt_en = 1'b0;
        step();
        check("c_run_addr",   imem_addr,  16'h0022);
        check("c_run_instr",  ifid_instr, 16'hA020);
        check("c_run_valid",  {15'd0, ifid_valid}, 16'd1);
        check("c_run_halted", {15'd0, halted}, 16'd0);
        step();
        check("c_run2_halted", {15'd0, halted}, 16'd0);
        check("c_run2_addr",   imem_addr, 16'h0024);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
